// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register and valid/ready input.
module uart_tx #(
  parameter int BAUD_END = 5207
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [12:0] BAUD_MAX = 13'(BAUD_END);
  state_t      state_q, state_d;
  logic [12:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, hold_q, hold_d;
  logic        hold_full_q, hold_full_d, ready_q, line_q, line_d, done_q, done_d;
  logic        accept, baud_end, reload;
  assign accept   = tx_valid & ready_q;
  assign baud_end = baud_q == BAUD_MAX;
  assign reload   = hold_full_q & (state_q == IDLE | (state_q == STOP & baud_end));
  assign tx_ready = ready_q;
  assign rs232_tx = line_q;
  assign tx_busy  = state_q != IDLE;
  assign tx_done  = done_q;
  always_comb begin
    state_d     = state_q;
    baud_d      = (state_q == IDLE || baud_end) ? '0 : baud_q + 13'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    line_d      = line_q;
    done_d      = 1'b0;
    hold_full_d = accept | (hold_full_q & ~reload);
    hold_d      = accept ? tx_data : hold_q;
    case (state_q)
      IDLE: if (hold_full_q) begin
        state_d = START;
        shift_d = hold_q;
        line_d  = 1'b0;
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
        line_d  = shift_q[0];
      end
      DATA: if (baud_end) begin
        bit_d   = bit_q + 3'd1;
        shift_d = shift_q >> 1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
        line_d  = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
      end
      STOP: if (baud_end) begin
        done_d  = 1'b1;
        state_d = hold_full_q ? START : IDLE;
        shift_d = hold_full_q ? hold_q : shift_q;
        line_d  = ~hold_full_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      line_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      line_q      <= line_d;
      done_q      <= done_d;
    end
  end
endmodule
